// File: rtl/i2s_mic_rx_pkg.sv
// Shared constants for the I2S microphone receiver slice.
package constants;

  localparam int SYNTH_WIDTH = 16;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_slot_t;

endpackage

// File: rtl/i2s_mic_rx_if.sv
// Sample stream from the I2S receiver to its consumer (valid/ready plus overrun flag).
interface i2s_mic_rx_if #(
  parameter int OUT_WIDTH = constants::SYNTH_WIDTH
);
  logic signed [OUT_WIDTH-1:0] sample_out;
  logic                        channel_out;
  logic                        valid_out;
  logic                        ready_in;
  logic                        overrun_out;

  modport master (output sample_out, channel_out, valid_out, overrun_out, input ready_in);
  modport slave  (input sample_out, channel_out, valid_out, overrun_out, output ready_in);
endinterface

// File: rtl/i2s_mic_rx_clkgen.sv
// Bit-clock divider: free-running counter, registered bclk and single-cycle rise/fall strobes.
module i2s_clkgen #(
  parameter int BCLK_DIV = 32
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  output logic bclk_out,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int HALF = BCLK_DIV / 2;
  localparam int CW   = $clog2(BCLK_DIV);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg + CW'(1);
    if (cnt_reg == CW'(BCLK_DIV - 1) || !enable_in) begin
      cnt_next = '0;
    end
  end

  // Strobes mark the last cycle before the bclk pin changes level.
  assign rise_stb = enable_in && (cnt_reg == CW'(HALF - 1));
  assign fall_stb = enable_in && (cnt_reg == CW'(BCLK_DIV - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_reg  <= '0;
      bclk_out <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      bclk_out <= (cnt_next >= CW'(HALF));
    end
  end
endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: drives bclk/ws, captures MSB-first words one bit after ws change,
// and presents them on a valid/ready stream with a sticky overrun flag.
module i2s_mic_rx
  import constants::*;
#(
  parameter int BCLK_DIV  = 32,
  parameter int SLOT_BITS = 32,
  parameter int MIC_WIDTH = 24,
  parameter int OUT_WIDTH = SYNTH_WIDTH,
  parameter int NUM_CH    = 2,
  parameter int CH_SEL    = 0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  input  logic data_in,
  output logic bclk_out,
  output logic ws_out,
  i2s_mic_rx_if.master out_if
);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [BW-1:0] BIDX_LAST = BW'(2 * SLOT_BITS - 1);

  logic                           rise_stb, fall_stb;
  logic [BW-1:0]                  bidx_reg, bidx_next;
  logic                           ws_reg, ws_next;
  logic [MIC_WIDTH-1:0]           shift_reg, shift_next;
  logic [OUT_WIDTH-1:0]           sample_reg, sample_next;
  logic                           channel_reg, channel_next;
  logic                           valid_reg, valid_next;
  logic                           overrun_reg, overrun_next;
  logic [BW-1:0]                  slot_pos;
  i2s_slot_t                      slot;
  logic                           capture, word_done;
  logic [MIC_WIDTH-1:0]           word;
  logic [MIC_WIDTH+OUT_WIDTH-1:0] word_ext;

  i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .enable_in (enable_in),
    .bclk_out  (bclk_out),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb)
  );

  assign slot     = ws_reg ? RIGHT : LEFT;
  assign slot_pos = ws_reg ? (bidx_reg - BW'(SLOT_BITS)) : bidx_reg;
  assign capture  = rise_stb
                 && (NUM_CH == 2 || slot == i2s_slot_t'(1'(CH_SEL)))
                 && (slot_pos >= BW'(1)) && (slot_pos <= BW'(MIC_WIDTH));
  assign word_done = capture && (slot_pos == BW'(MIC_WIDTH));
  assign word      = MIC_WIDTH'({shift_reg, data_in});
  // One shift covers both truncation and zero-fill alignment.
  assign word_ext  = {word, {OUT_WIDTH{1'b0}}};

  always_comb begin
    bidx_next    = bidx_reg;
    shift_next   = shift_reg;
    sample_next  = sample_reg;
    channel_next = channel_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (fall_stb) begin
      bidx_next = (bidx_reg == BIDX_LAST) ? '0 : bidx_reg + BW'(1);
    end
    ws_next = (bidx_next >= BW'(SLOT_BITS));
    if (capture) begin
      shift_next = word;
    end
    if (valid_reg && out_if.ready_in) begin
      valid_next = 1'b0;
    end
    if (word_done) begin
      sample_next  = OUT_WIDTH'(word_ext >> MIC_WIDTH);
      channel_next = 1'(slot);
      valid_next   = 1'b1;
      if (valid_reg && !out_if.ready_in) begin
        overrun_next = 1'b1;
      end
    end
    if (!enable_in) begin
      bidx_next    = BIDX_LAST;
      ws_next      = 1'b1;
      shift_next   = '0;
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bidx_reg    <= BIDX_LAST;
      ws_reg      <= 1'b1;
      shift_reg   <= '0;
      sample_reg  <= '0;
      channel_reg <= 1'b0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      bidx_reg    <= bidx_next;
      ws_reg      <= ws_next;
      shift_reg   <= shift_next;
      sample_reg  <= sample_next;
      channel_reg <= channel_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign ws_out             = ws_reg;
  assign out_if.sample_out  = sample_reg;
  assign out_if.channel_out = channel_reg;
  assign out_if.valid_out   = valid_reg;
  assign out_if.overrun_out = overrun_reg;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench: three receivers in lockstep fed by one I2S mic model; expected words queued per receiver.
module tb_i2s_mic_rx;
  localparam int DIV = 32;
  localparam int SLOT = 32;
  localparam int MW = 24;

  typedef struct packed {
    logic [31:0] s;
    logic        ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic data = 1'b0;
  logic bclk_a, ws_a, bclk_b, ws_b, bclk_c, ws_c;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_mic_rx_if #(.OUT_WIDTH(16)) if_a ();
  i2s_mic_rx_if #(.OUT_WIDTH(32)) if_b ();
  i2s_mic_rx_if #(.OUT_WIDTH(16)) if_c ();

  i2s_mic_rx #(.OUT_WIDTH(16)) dut_a (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .data_in(data),
    .bclk_out(bclk_a), .ws_out(ws_a), .out_if(if_a));
  i2s_mic_rx #(.OUT_WIDTH(32)) dut_b (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .data_in(data),
    .bclk_out(bclk_b), .ws_out(ws_b), .out_if(if_b));
  i2s_mic_rx #(.OUT_WIDTH(16), .NUM_CH(1), .CH_SEL(1)) dut_c (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .data_in(data),
    .bclk_out(bclk_c), .ws_out(ws_c), .out_if(if_c));

  // Mic model state
  logic [MW-1:0] left_word = 24'h123456;
  logic [MW-1:0] right_word = 24'hFEDCBA;
  logic [MW-1:0] cur_word = '0;
  logic          cur_slot = 1'b0;
  int            pos = 99;
  int            push_a = 0;
  exp_t          q_a[$];
  exp_t          q_b[$];
  exp_t          q_c[$];

  // Scoreboard observations
  int          hs_a = 0, hs_b = 0, hs_c = 0;
  int          last_hs_a = 0, prev_hs_a = 0, last_hs_c = 0, prev_hs_c = 0;
  logic [15:0] last_a_left = '0;
  logic [31:0] last_b_left = '0;
  logic        last_c_ch = 1'b0;

  // I2S mic: new bit after each bclk fall, MSB one bit after the ws change.
  initial begin : mic
    logic prev_bclk, prev_ws;
    prev_bclk = 1'b0;
    prev_ws = 1'b1;
    forever begin
      @(negedge clk);
      if (rst || !en) begin
        pos = 99;
      end else if (prev_bclk && !bclk_a) begin
        if (ws_a != prev_ws) begin
          pos = 0;
          cur_slot = ws_a;
          cur_word = ws_a ? right_word : left_word;
        end else begin
          pos++;
        end
        if (pos >= 1 && pos <= MW) data = cur_word[MW-pos];
        else data = 1'($urandom_range(0, 1));
        if (pos == MW) begin
          q_a.push_back('{s: {16'h0, cur_word[23:8]}, ch: cur_slot});
          q_b.push_back('{s: {cur_word, 8'h00}, ch: cur_slot});
          if (cur_slot) q_c.push_back('{s: {16'h0, cur_word[23:8]}, ch: 1'b1});
          push_a++;
        end
      end
      prev_bclk = bclk_a;
      prev_ws = ws_a;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_a.valid_out && if_a.ready_in) begin
        prev_hs_a = last_hs_a; last_hs_a = cyc; hs_a++;
        if (!if_a.channel_out) last_a_left = if_a.sample_out;
        compared++;
        if (q_a.size() == 0) begin
          mismatched++;
          $display("FAIL mon_a: got sample=%h ch=%0d, required no valid", if_a.sample_out, if_a.channel_out);
        end else begin
          e = q_a.pop_front();
          if ({16'h0, if_a.sample_out} !== e.s || if_a.channel_out !== e.ch) begin
            mismatched++;
            $display("FAIL mon_a: got sample=%h ch=%0d, required sample=%h ch=%0d", if_a.sample_out, if_a.channel_out, e.s[15:0], e.ch);
          end else $display("mon_a: sample=%h ch=%0d ok", if_a.sample_out, if_a.channel_out);
        end
      end
      if (if_b.valid_out && if_b.ready_in) begin
        hs_b++;
        if (!if_b.channel_out) last_b_left = if_b.sample_out;
        compared++;
        if (q_b.size() == 0) begin
          mismatched++;
          $display("FAIL mon_b: got sample=%h ch=%0d, required no valid", if_b.sample_out, if_b.channel_out);
        end else begin
          e = q_b.pop_front();
          if (if_b.sample_out !== e.s || if_b.channel_out !== e.ch) begin
            mismatched++;
            $display("FAIL mon_b: got sample=%h ch=%0d, required sample=%h ch=%0d", if_b.sample_out, if_b.channel_out, e.s, e.ch);
          end else $display("mon_b: sample=%h ch=%0d ok", if_b.sample_out, if_b.channel_out);
        end
      end
      if (if_c.valid_out && if_c.ready_in) begin
        prev_hs_c = last_hs_c; last_hs_c = cyc; hs_c++;
        last_c_ch = if_c.channel_out;
        compared++;
        if (q_c.size() == 0) begin
          mismatched++;
          $display("FAIL mon_c: got sample=%h ch=%0d, required no valid", if_c.sample_out, if_c.channel_out);
        end else begin
          e = q_c.pop_front();
          if ({16'h0, if_c.sample_out} !== e.s || if_c.channel_out !== e.ch) begin
            mismatched++;
            $display("FAIL mon_c: got sample=%h ch=%0d, required sample=%h ch=%0d", if_c.sample_out, if_c.channel_out, e.s[15:0], e.ch);
          end else $display("mon_c: sample=%h ch=%0d ok", if_c.sample_out, if_c.channel_out);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    if_a.ready_in = 1'b1; if_b.ready_in = 1'b1; if_c.ready_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    compared++; if (bclk_a !== 1'b0) begin mismatched++; $display("FAIL reset_bclk: got %b, required 0", bclk_a); end
    compared++; if (ws_a !== 1'b1) begin mismatched++; $display("FAIL reset_ws: got %b, required 1", ws_a); end
    compared++; if (if_a.sample_out !== 16'h0) begin mismatched++; $display("FAIL reset_sample: got %h, required 0", if_a.sample_out); end
    compared++; if (if_a.channel_out !== 1'b0) begin mismatched++; $display("FAIL reset_channel: got %b, required 0", if_a.channel_out); end
    compared++; if (if_a.valid_out !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b, required 0", if_a.valid_out); end
    compared++; if (if_a.overrun_out !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b, required 0", if_a.overrun_out); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int n = 0;
    while (hs_a < 4 && n < 6000) begin @(negedge clk); n++; end
    compared++; if (hs_a < 4) begin mismatched++; $display("FAIL basic_timeout: got %0d words, required 4", hs_a); end
    compared++; if (last_a_left !== 16'h1234) begin mismatched++; $display("FAIL basic_left: got %h, required 1234", last_a_left); end
    compared++;
    if (last_hs_a - prev_hs_a != SLOT * DIV) begin
      mismatched++; $display("FAIL basic_rate: got %0d cycles between words, required %0d", last_hs_a - prev_hs_a, SLOT * DIV);
    end
  endtask

  task automatic test_width32();
    int n = 0;
    int base = hs_b;
    left_word = 24'h800001;
    while (hs_b < base + 4 && n < 6000) begin @(negedge clk); n++; end
    compared++; if (hs_b < base + 4) begin mismatched++; $display("FAIL w32_timeout: got %0d words, required %0d", hs_b - base, 4); end
    compared++; if (last_b_left !== 32'h80000100) begin mismatched++; $display("FAIL w32_left: got %h, required 80000100", last_b_left); end
  endtask

  task automatic test_nch1();
    int n = 0;
    int base = hs_c;
    while (hs_c < base + 2 && n < 6000) begin @(negedge clk); n++; end
    compared++; if (hs_c < base + 2) begin mismatched++; $display("FAIL nch1_timeout: got %0d words, required 2", hs_c - base); end
    compared++; if (last_c_ch !== 1'b1) begin mismatched++; $display("FAIL nch1_channel: got %b, required 1", last_c_ch); end
    compared++;
    if (last_hs_c - prev_hs_c != 2 * SLOT * DIV) begin
      mismatched++; $display("FAIL nch1_rate: got %0d cycles between words, required %0d", last_hs_c - prev_hs_c, 2 * SLOT * DIV);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int base;
    logic [15:0] exp_b;
    while (q_a.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    @(posedge clk); #1 if_a.ready_in = 1'b0;
    base = push_a; n = 0;
    while (push_a < base + 2 && n < 3000) begin @(negedge clk); n++; end
    compared++; if (push_a < base + 2) begin mismatched++; $display("FAIL bp_timeout: got %0d words, required 2", push_a - base); end
    repeat (DIV) @(negedge clk);
    exp_b = (q_a.size() > 0) ? q_a[$].s[15:0] : 16'hxxxx;
    compared++; if (if_a.valid_out !== 1'b1) begin mismatched++; $display("FAIL bp_valid_held: got %b, required 1", if_a.valid_out); end
    compared++; if (if_a.overrun_out !== 1'b1) begin mismatched++; $display("FAIL bp_overrun: got %b, required 1", if_a.overrun_out); end
    compared++; if (if_a.sample_out !== exp_b) begin mismatched++; $display("FAIL bp_sample_b: got %h, required %h", if_a.sample_out, exp_b); end
    if (q_a.size() > 0) void'(q_a.pop_front());  // word A was overwritten
    @(posedge clk); #1 if_a.ready_in = 1'b1;
    @(posedge clk); @(negedge clk);
    compared++; if (if_a.valid_out !== 1'b0) begin mismatched++; $display("FAIL bp_valid_drop: got %b, required 0", if_a.valid_out); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int base;
    while (!(pos == 10 && cur_slot == 1'b0) && n < 3000) begin @(negedge clk); n++; end
    compared++; if (!(pos == 10 && cur_slot == 1'b0)) begin mismatched++; $display("FAIL rstmid_timeout: got pos %0d, required 10", pos); end
    rst = 1'b1;
    left_word = 24'hA5C3E1;
    repeat (3) @(negedge clk);
    q_a.delete(); q_b.delete(); q_c.delete();
    compared++; if (bclk_a !== 1'b0) begin mismatched++; $display("FAIL rstmid_bclk: got %b, required 0", bclk_a); end
    compared++; if (ws_a !== 1'b1) begin mismatched++; $display("FAIL rstmid_ws: got %b, required 1", ws_a); end
    compared++; if (if_a.sample_out !== 16'h0) begin mismatched++; $display("FAIL rstmid_sample: got %h, required 0", if_a.sample_out); end
    compared++; if (if_a.valid_out !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %b, required 0", if_a.valid_out); end
    compared++; if (if_a.overrun_out !== 1'b0) begin mismatched++; $display("FAIL rstmid_overrun: got %b, required 0", if_a.overrun_out); end
    @(posedge clk); #1 rst = 1'b0;
    base = hs_a; n = 0;
    while (hs_a < base + 2 && n < 3000) begin @(negedge clk); n++; end
    compared++; if (hs_a < base + 2) begin mismatched++; $display("FAIL rstmid_resume: got %0d words, required 2", hs_a - base); end
    compared++; if (last_a_left !== 16'hA5C3) begin mismatched++; $display("FAIL rstmid_left: got %h, required a5c3", last_a_left); end
  endtask

  task automatic test_enable();
    int n = 0;
    int base;
    int bad = 0;
    logic ws_hi = 1'b0;
    logic saw_high = 1'b0;
    while (q_a.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    @(posedge clk); #1 if_a.ready_in = 1'b0;
    base = push_a; n = 0;
    while (push_a < base + 2 && n < 3000) begin @(negedge clk); n++; end
    repeat (DIV) @(negedge clk);
    compared++; if (if_a.overrun_out !== 1'b1) begin mismatched++; $display("FAIL en_overrun_set: got %b, required 1", if_a.overrun_out); end
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk);
    q_a.delete(); q_b.delete(); q_c.delete();
    #1 if_a.ready_in = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bclk_a !== 1'b0 || if_a.valid_out !== 1'b0 || if_b.valid_out !== 1'b0) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL en_idle: got %0d active cycles, required 0", bad); end
    compared++; if (if_a.overrun_out !== 1'b0) begin mismatched++; $display("FAIL en_overrun_clr: got %b, required 0", if_a.overrun_out); end
    compared++; if (ws_a !== 1'b1) begin mismatched++; $display("FAIL en_ws_idle: got %b, required 1", ws_a); end
    @(posedge clk); #1 en = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (bclk_a) begin saw_high = 1'b1; ws_hi = ws_a; end
      else if (saw_high) break;
    end
    compared++; if (ws_hi !== 1'b1) begin mismatched++; $display("FAIL en_ws_before_fall: got %b, required 1", ws_hi); end
    compared++; if (!saw_high || ws_a !== 1'b0) begin mismatched++; $display("FAIL en_ws_after_fall: got %b, required 0", ws_a); end
    base = hs_a; n = 0;
    while (hs_a < base + 2 && n < 3000) begin @(negedge clk); n++; end
    compared++; if (hs_a < base + 2) begin mismatched++; $display("FAIL en_resume: got %0d words, required 2", hs_a - base); end
  endtask

  task automatic test_drain();
    int n = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 3000) begin @(negedge clk); n++; end
    compared++;
    if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
      mismatched++; $display("FAIL drain: got %0d undelivered words, required 0", q_a.size() + q_b.size() + q_c.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width32();
    test_nch1();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/i2s_mic_rx.md
I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 Parameter BCLK_DIV, default 32, clk_in cycles per bclk period; even, >=4.
REQ-002 Parameter SLOT_BITS, default 32, bclk periods per WS half-frame; >= MIC_WIDTH+1.
REQ-003 Parameter MIC_WIDTH, default 24, significant bits per mic word, MSB first, two's complement.
REQ-004 Parameter OUT_WIDTH, default constants::SYNTH_WIDTH, width of sample_out.
REQ-005 Parameter NUM_CH, default 2, legal values 1 or 2.
REQ-006 Parameter CH_SEL, default 0, slot captured when NUM_CH=1 (0=left/WS low, 1=right/WS high).
REQ-007 clk_in  input  1  system clock; all logic SHALL be clocked on posedge clk_in only, no derived-clock edges.
REQ-008 rst_in  input  1  asynchronous, active-high reset.
REQ-009 enable_in  input  1  run enable, synchronous.
REQ-010 data_in  input  1  I2S serial data from mic(s).
REQ-011 ready_in  input  1  consumer accepts sample this cycle.
REQ-012 bclk_out  output  1  bit clock to mic.
REQ-013 ws_out  output  1  word select to mic; 0=left slot, 1=right slot.
REQ-014 sample_out  output  OUT_WIDTH  signed captured sample.
REQ-015 channel_out  output  1  slot of sample_out (0 left, 1 right).
REQ-016 valid_out  output  1  sample_out/channel_out valid.
REQ-017 overrun_out  output  1  sticky flag, sample dropped while valid_out && !ready_in.

Function
REQ-018 Divider counter cnt SHALL run 0..BCLK_DIV-1 and wrap; bclk_out SHALL be low for cnt < BCLK_DIV/2, high otherwise, registered.
REQ-019 Rise strobe SHALL fire in the cycle cnt==BCLK_DIV/2-1; fall strobe in the cycle cnt==BCLK_DIV-1.
REQ-020 Bit index bidx SHALL run 0..2*SLOT_BITS-1, advancing and wrapping on each fall strobe; ws_out SHALL equal (bidx >= SLOT_BITS), registered with bidx.
REQ-021 Slot position p = bidx mod SLOT_BITS; per I2S one-bit delay, MSB SHALL be sampled at the rise strobe with p==1, LSB at p==MIC_WIDTH; other positions SHALL be ignored.
REQ-022 data_in SHALL be sampled only on rise strobes.
REQ-023 Capture SHALL occur in slot 0 and slot 1 when NUM_CH=2, and only in slot CH_SEL when NUM_CH=1.
REQ-024 Alignment: if OUT_WIDTH <= MIC_WIDTH, sample_out SHALL be the top OUT_WIDTH bits (truncate LSBs); otherwise the MIC_WIDTH word SHALL be MSB-aligned with zero-filled LSBs.
REQ-025 valid_out, sample_out and channel_out SHALL update in the clk_in cycle after the LSB rise strobe (latency 1 cycle).
REQ-026 Handshake: transfer occurs when valid_out && ready_in; valid_out SHALL stay high and outputs stable until transfer.
REQ-027 A new word completing while valid_out && !ready_in SHALL overwrite sample_out/channel_out, keep valid_out high, and set overrun_out.
REQ-028 A new word completing in the same cycle as a transfer SHALL load and keep valid_out high; no overrun.
REQ-029 overrun_out SHALL clear only on reset or enable_in low.
REQ-030 enable_in low SHALL force cnt, bidx, shift register and valid_out to reset values on the next edge, bclk_out low, partial word discarded.

Reset
REQ-031 On rst_in: cnt=0, bidx=2*SLOT_BITS-1, bclk_out=0, ws_out=1, sample_out=0, channel_out=0, valid_out=0, overrun_out=0, shift register=0.
REQ-032 Reset mid-word SHALL discard the partial capture; first post-reset fall strobe SHALL move bidx to 0 (ws_out=0).

Structure
REQ-033 SYNTH_WIDTH and an i2s_slot_t enum (LEFT=0, RIGHT=1) SHALL live in package constants.
REQ-034 Sub-module i2s_clkgen SHALL own cnt, bclk_out and rise/fall strobes; i2s_mic_rx owns bidx, ws_out, capture and handshake.

Verification
REQ-035 Defaults, OUT_WIDTH=16, ready_in=1: left 0x123456, right 0xFEDCBA -> sample_out 0x1234 ch0, then 0xFEDC ch1, one valid per slot, 48 kHz per channel at 98.304 MHz.
REQ-036 OUT_WIDTH=32, left 0x800001 -> sample_out 0x80000100.
REQ-037 NUM_CH=1, CH_SEL=1 -> only right words delivered, channel_out=1, one valid per 64 bclk.
REQ-038 ready_in=0 across two words A, B -> sample_out=B, valid_out held, overrun_out=1; ready_in=1 -> valid_out drops next cycle.
REQ-039 rst_in pulsed at bit 10 of left slot -> outputs at reset values, no valid for partial word, next full left word captured correctly.
REQ-040 enable_in low for 100 cycles -> bclk_out low, no valid, overrun_out cleared; re-enable -> bidx restarts, ws_out 1->0 on first fall strobe.
